// File: rtl/tdm_demux_1to8_if.sv
// rtl/tdm_demux_1to8_if.sv - serial-lane demux bus: din stream, lane outputs, frame handshake
interface tdm_demux_1to8_if;
   logic       din;
   logic       din_valid;
   logic       sel_mode;
   logic [2:0] sel;
   logic       frame_sync;
   logic [7:0] lane_out;
   logic [7:0] lane_strobe;
   logic [2:0] slot;
   logic [7:0] frame_data;
   logic       frame_valid;
   logic       frame_ready;
   logic       overrun;

   modport master (
      output din, din_valid, sel_mode, sel, frame_sync, frame_ready,
      input  lane_out, lane_strobe, slot, frame_data, frame_valid, overrun
   );

   modport slave (
      input  din, din_valid, sel_mode, sel, frame_sync, frame_ready,
      output lane_out, lane_strobe, slot, frame_data, frame_valid, overrun
   );
endinterface

// File: rtl/tdm_demux_1to8.sv
// rtl/tdm_demux_1to8.sv - 1:8 time-division demux with auto-slot frame assembly
// Steers one serial bit per valid cycle to a lane; auto mode packs 8 bits into a handshaked frame.
module tdm_demux_1to8 #(
   parameter logic [7:0] RESET_LANES = 8'h00
) (
   input logic              clk,
   input logic              rst,
   tdm_demux_1to8_if.slave  bus
);

   typedef enum logic {COLLECT, FULL} state_t;

   state_t     state_q, state_d;
   logic [7:0] lane_out_q, lane_out_d;
   logic [7:0] lane_strobe_q, lane_strobe_d;
   logic [2:0] slot_q, slot_d;
   logic [7:0] asm_q, asm_d;
   logic [7:0] frame_data_q, frame_data_d;
   logic       overrun_q, overrun_d;

   logic [2:0] target;
   logic [7:0] asm_next;
   logic       handshake;
   logic       complete;

   always_comb begin
      lane_out_d    = lane_out_q;
      lane_strobe_d = 8'h00;
      slot_d        = slot_q;
      asm_d         = asm_q;
      frame_data_d  = frame_data_q;
      overrun_d     = overrun_q;
      state_d       = state_q;
      complete      = 1'b0;
      asm_next      = asm_q;
      handshake     = (state_q == FULL) && bus.frame_ready;

      if (bus.sel_mode)
         target = bus.sel;
      else if (bus.frame_sync)
         target = 3'd0;
      else
         target = slot_q;

      if (bus.din_valid) begin
         lane_out_d[target] = bus.din;
         lane_strobe_d      = 8'h01 << target;
         if (!bus.sel_mode) begin
            // A sync bit restarts the frame, so the partial assembly is dropped.
            asm_next         = bus.frame_sync ? 8'h00 : asm_q;
            asm_next[target] = bus.din;
            asm_d            = asm_next;
            if (target == 3'd7) begin
               complete     = 1'b1;
               frame_data_d = asm_next;
               slot_d       = 3'd0;
            end else begin
               slot_d = target + 3'd1;
            end
         end
      end

      if (complete) begin
         if ((state_q == FULL) && !handshake)
            overrun_d = 1'b1;
         state_d = FULL;
      end else if (handshake) begin
         state_d = COLLECT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= COLLECT;
         lane_out_q    <= RESET_LANES;
         lane_strobe_q <= 8'h00;
         slot_q        <= 3'd0;
         asm_q         <= 8'h00;
         frame_data_q  <= 8'h00;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         lane_out_q    <= lane_out_d;
         lane_strobe_q <= lane_strobe_d;
         slot_q        <= slot_d;
         asm_q         <= asm_d;
         frame_data_q  <= frame_data_d;
         overrun_q     <= overrun_d;
      end
   end

   assign bus.lane_out    = lane_out_q;
   assign bus.lane_strobe = lane_strobe_q;
   assign bus.slot        = slot_q;
   assign bus.frame_data  = frame_data_q;
   assign bus.frame_valid = (state_q == FULL);
   assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// tb/tb_tdm_demux_1to8.sv - scoreboard bench for tdm_demux_1to8
module tb_tdm_demux_1to8;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic [7:0] exp_q[$];

   tdm_demux_1to8_if bus();

   tdm_demux_1to8 #(.RESET_LANES(8'h00)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      logic [7:0] exp;
      #1;
      if (bus.frame_valid && bus.frame_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected_frame got=%h expected=none", bus.frame_data);
         end else begin
            exp = exp_q.pop_front();
            if (bus.frame_data !== exp) begin
               errors++;
               $display("FAIL scoreboard_frame got=%h expected=%h", bus.frame_data, exp);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.din       = b;
      bus.din_valid = 1'b1;
      tick();
      bus.din_valid = 1'b0;
   endtask

   task automatic idle();
      bus.din_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++;
      if (bus.lane_out !== 8'h00 || bus.lane_strobe !== 8'h00 || bus.slot !== 3'd0 ||
          bus.frame_data !== 8'h00 || bus.frame_valid !== 1'b0 || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got lane=%h strobe=%h slot=%0d fd=%h fv=%b ov=%b expected 00 00 0 00 0 0",
                  bus.lane_out, bus.lane_strobe, bus.slot, bus.frame_data, bus.frame_valid, bus.overrun);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      logic [7:0] byte_v = 8'h4D;
      bus.frame_ready = 1'b1;
      exp_q.push_back(byte_v);
      for (int i = 0; i < 8; i++) begin
         send_bit(byte_v[i]);
         checks++;
         if (bus.lane_strobe !== (8'h01 << i) || bus.slot !== 3'((i + 1) % 8)) begin
            errors++;
            $display("FAIL basic_walk bit=%0d strobe=%h slot=%0d expected strobe=%h slot=%0d",
                     i, bus.lane_strobe, bus.slot, 8'h01 << i, (i + 1) % 8);
         end
         checks++;
         if (bus.frame_valid !== (i == 7)) begin
            errors++;
            $display("FAIL basic_frame_valid bit=%0d got=%b expected=%b", i, bus.frame_valid, i == 7);
         end
      end
      checks++;
      if (bus.frame_data !== 8'h4D || bus.lane_out !== 8'h4D) begin
         errors++;
         $display("FAIL basic_data fd=%h lane=%h expected 4d 4d", bus.frame_data, bus.lane_out);
      end
      idle();
      checks++;
      if (bus.frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_pulse frame_valid=%b expected=0", bus.frame_valid);
      end
   endtask

   task automatic test_gapped();
      logic [7:0] byte_v = 8'hA5;
      int waited;
      bus.frame_ready = 1'b1;
      exp_q.push_back(byte_v);
      for (int i = 0; i < 8; i++) begin
         if (i < 7) begin
            send_bit(byte_v[i]);
            for (int g = 0; g < 2; g++) begin
               idle();
               checks++;
               if (bus.lane_strobe !== 8'h00 || bus.slot !== 3'(i + 1)) begin
                  errors++;
                  $display("FAIL gapped_idle bit=%0d strobe=%h slot=%0d expected strobe=00 slot=%0d",
                           i, bus.lane_strobe, bus.slot, i + 1);
               end
            end
         end else begin
            bus.din       = byte_v[i];
            bus.din_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.din_valid = 1'b0;
         end
      end
      waited = 0;
      while (bus.frame_valid !== 1'b1 && waited < 10) begin
         idle();
         waited++;
      end
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'hA5) begin
         errors++;
         $display("FAIL gapped_frame fv=%b fd=%h expected fv=1 fd=a5", bus.frame_valid, bus.frame_data);
      end
      idle();
   endtask

   task automatic test_overrun();
      logic [7:0] f1 = 8'h0F;
      logic [7:0] f2 = 8'hF0;
      bus.frame_ready = 1'b0;
      for (int i = 0; i < 8; i++) send_bit(f1[i]);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h0F || bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_first fv=%b fd=%h ov=%b expected 1 0f 0",
                  bus.frame_valid, bus.frame_data, bus.overrun);
      end
      exp_q.push_back(f2);
      for (int i = 0; i < 8; i++) send_bit(f2[i]);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'hF0 || bus.overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_second fv=%b fd=%h ov=%b expected 1 f0 1",
                  bus.frame_valid, bus.frame_data, bus.overrun);
      end
      bus.frame_ready = 1'b1;
      idle();
      idle();
      checks++;
      if (bus.frame_valid !== 1'b0 || bus.overrun !== 1'b1) begin
         errors++;
         $display("FAIL overrun_sticky fv=%b ov=%b expected 0 1", bus.frame_valid, bus.overrun);
      end
      do_reset();
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear got=%b expected=0", bus.overrun);
      end
   endtask

   task automatic test_frame_sync();
      bus.frame_ready = 1'b1;
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      exp_q.push_back(8'hFF);
      bus.frame_sync = 1'b1;
      send_bit(1'b1);
      bus.frame_sync = 1'b0;
      checks++;
      if (bus.slot !== 3'd1 || bus.lane_strobe !== 8'h01) begin
         errors++;
         $display("FAIL sync_slot slot=%0d strobe=%h expected 1 01", bus.slot, bus.lane_strobe);
      end
      for (int i = 0; i < 7; i++) send_bit(1'b1);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'hFF) begin
         errors++;
         $display("FAIL sync_frame fv=%b fd=%h expected 1 ff", bus.frame_valid, bus.frame_data);
      end
      idle();
   endtask

   task automatic test_manual();
      do_reset();
      bus.frame_ready = 1'b1;
      send_bit(1'b0);
      send_bit(1'b0);
      bus.sel_mode = 1'b1;
      bus.sel      = 3'd5;
      send_bit(1'b1);
      checks++;
      if (bus.lane_strobe !== 8'h20 || bus.lane_out !== 8'h20) begin
         errors++;
         $display("FAIL manual_sel5 strobe=%h lane=%h expected 20 20", bus.lane_strobe, bus.lane_out);
      end
      bus.sel = 3'd2;
      send_bit(1'b1);
      checks++;
      if (bus.lane_strobe !== 8'h04 || bus.lane_out !== 8'h24 || bus.slot !== 3'd2 ||
          bus.frame_valid !== 1'b0) begin
         errors++;
         $display("FAIL manual_sel2 strobe=%h lane=%h slot=%0d fv=%b expected 04 24 2 0",
                  bus.lane_strobe, bus.lane_out, bus.slot, bus.frame_valid);
      end
      // Back to auto: slots 0,1 kept their zeros, so six ones complete 8'hFC.
      bus.sel_mode = 1'b0;
      exp_q.push_back(8'hFC);
      for (int i = 2; i < 8; i++) send_bit(1'b1);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'hFC) begin
         errors++;
         $display("FAIL manual_resume fv=%b fd=%h expected 1 fc", bus.frame_valid, bus.frame_data);
      end
      idle();
   endtask

   task automatic test_async_reset();
      logic [7:0] byte_v = 8'h3C;
      bus.frame_ready = 1'b1;
      for (int i = 0; i < 4; i++) send_bit(byte_v[i]);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.lane_out !== 8'h00 || bus.lane_strobe !== 8'h00 || bus.slot !== 3'd0 ||
          bus.frame_valid !== 1'b0 || bus.frame_data !== 8'h00) begin
         errors++;
         $display("FAIL async_reset lane=%h strobe=%h slot=%0d fv=%b fd=%h expected 00 00 0 0 00",
                  bus.lane_out, bus.lane_strobe, bus.slot, bus.frame_valid, bus.frame_data);
      end
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(byte_v);
      for (int i = 0; i < 8; i++) send_bit(byte_v[i]);
      checks++;
      if (bus.frame_valid !== 1'b1 || bus.frame_data !== 8'h3C) begin
         errors++;
         $display("FAIL async_refill fv=%b fd=%h expected 1 3c", bus.frame_valid, bus.frame_data);
      end
      idle();
   endtask

   initial begin
      checks          = 0;
      errors          = 0;
      rst             = 1'b1;
      bus.din         = 1'b0;
      bus.din_valid   = 1'b0;
      bus.sel_mode    = 1'b0;
      bus.sel         = 3'd0;
      bus.frame_sync  = 1'b0;
      bus.frame_ready = 1'b0;

      test_reset();
      test_basic_frame();
      test_gapped();
      test_overrun();
      test_frame_sync();
      test_manual();
      test_async_reset();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain remaining=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
